reg_alu_exec: RTL and testbench

//  Parametrised successor of the 2-bit AND AX,BX executor: NREGS x WIDTH register file

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 47 ++++
 rtl/reg_alu_exec.sv | 99 +++++++++
 tb/tb_reg_alu_exec.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and register-index definitions for the register-file ALU executor.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR = 4'h5;
  localparam logic [OP_W-1:0] OP_NOT = 4'h6;
  localparam logic [OP_W-1:0] OP_AND = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR = 4'h9;

  localparam int R_AX = 0;
  localparam int R_BX = 1;
  localparam int R_CX = 2;
  localparam int R_DX = 3;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op <= OP_SHR;
  endfunction

  // Legal non-NOP opcodes write dst and update flags.
  function automatic logic writes_dst(input logic [OP_W-1:0] op);
    return is_legal_op(op) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and carry/borrow/shifted-out bit for one opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the extended difference is the borrow (a < b).
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      OP_MOV: result = b;
      OP_ADD: {carry, result} = sum;
      OP_SUB: {carry, result} = diff;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_AND: result = a & b;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: begin
        result = a;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_alu_exec.sv
// NREGS x WIDTH register file with a 2-stage "dst <= dst OP src" executor.
// Define ALU_FLAGS_EN to add the registered zero/carry flag outputs.
module reg_alu_exec
  import alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [RA_W-1:0]  in_dst,
  input  logic [RA_W-1:0]  in_src,
  input  logic             ext_we,
  input  logic [RA_W-1:0]  ext_addr,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [RA_W-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic             err
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c
`endif
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RA_W-1:0] dst;
    logic [RA_W-1:0] src;
  } instr_t;

  logic [NREGS-1:0][WIDTH-1:0] rf;
  logic [STAGES:1]             vld_pipe;
  instr_t                      s2;
  logic                        accept;
  logic [WIDTH-1:0]            alu_res;
  logic                        alu_carry;
  logic                        retire_wr;

  assign in_ready  = ~ext_we;
  assign accept    = in_valid & in_ready;
  assign rd_data   = rf[rd_addr];
  assign retire_wr = vld_pipe[1] & writes_dst(s2.op);
  assign done      = vld_pipe[2];

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (s2.op),
    .a      (rf[s2.dst]),
    .b      (rf[s2.src]),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // vld_pipe[1]: instruction sits in execute; vld_pipe[2]: retired last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s2       <= '0;
      err      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], accept};
      err      <= vld_pipe[1] & ~is_legal_op(s2.op);
      if (accept) s2 <= '{op: in_op, dst: in_dst, src: in_src};
    end
  end

  // External load is applied last so it overrides a same-edge retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '0;
    end else begin
      if (retire_wr) rf[s2.dst] <= alu_res;
      if (ext_we)    rf[ext_addr] <= ext_data;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (retire_wr) begin
      flag_z <= (alu_res == '0);
      flag_c <= alu_carry;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = alu_carry;
`endif

endmodule

// File: tb/tb_reg_alu_exec.sv
// Directed plus randomized bench for reg_alu_exec against an arithmetic reference model.
module tb_reg_alu_exec;

  localparam int WIDTH = 4;
  localparam int NREGS = 4;
  localparam int RA_W  = 2;
  localparam int M     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [RA_W-1:0]  in_dst;
  logic [RA_W-1:0]  in_src;
  logic             ext_we;
  logic [RA_W-1:0]  ext_addr;
  logic [WIDTH-1:0] ext_data;
  logic [RA_W-1:0]  rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             done;
  logic             err;
`ifdef ALU_FLAGS_EN
  logic             flag_z;
  logic             flag_c;
`endif

  int vectors = 0;
  int miscompares = 0;

  int m_rf[NREGS];
  int m_z, m_c, m_err;

  reg_alu_exec #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_src(in_src), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_data(ext_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .done(done), .err(err)
`ifdef ALU_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int addr, input int exp);
    rd_addr = addr[RA_W-1:0];
    #1;
    chk(tag, {28'd0, rd_data}, exp);
  endtask

  task automatic ext_load(input int addr, input int data);
    ext_we = 1'b1; ext_addr = addr[RA_W-1:0]; ext_data = data[WIDTH-1:0];
    tick();
    ext_we = 1'b0;
  endtask

  task automatic issue(input int op, input int d, input int s);
    in_valid = 1'b1; in_op = op[3:0]; in_dst = d[RA_W-1:0]; in_src = s[RA_W-1:0];
  endtask

  // Reference semantics from the opcode table, in plain integer arithmetic.
  task automatic model_retire(input int op, input int d, input int s);
    int a, b, r, c;
    a = m_rf[d]; b = m_rf[s]; r = a; c = 0;
    m_err = (op > 9);
    if (op == 0 || op > 9) return;
    case (op)
      1: r = b;
      2: begin r = (a + b) % M; c = (a + b) >= M; end
      3: begin r = (a - b + M) % M; c = a < b; end
      4: r = a | b;
      5: r = a ^ b;
      6: r = (M - 1) - a;
      7: r = a & b;
      8: begin r = (a * 2) % M; c = a >= M / 2; end
      default: begin r = a / 2; c = a % 2; end
    endcase
    m_rf[d] = r; m_z = (r == 0); m_c = c;
  endtask

  initial begin
    int pend_v, pend_op, pend_d, pend_s, exp_done, exp_err, ra;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_dst = '0; in_src = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; rd_addr = '0;
    #20;
    for (int i = 0; i < NREGS; i++) rd_chk("reset_rf", i, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // AND AX,BX
    ext_load(0, 4'b1011);
    ext_load(1, 4'b0110);
    issue(7, 0, 1);
    tick();
    in_valid = 1'b0;
    chk("and_not_yet", {31'd0, done}, 0);
    tick();
    chk("and_done", {31'd0, done}, 1);
    chk("and_err", {31'd0, err}, 0);
    rd_chk("and_ax", 0, 4'b0010);
    rd_chk("and_bx", 1, 4'b0110);
    tick();
    chk("and_done_pulse", {31'd0, done}, 0);

    // back-to-back ADD AX,BX
    ext_load(0, 5);
    ext_load(1, 6);
    issue(2, 0, 1);
    tick();
    tick();
    in_valid = 1'b0;
    chk("add1_done", {31'd0, done}, 1);
    rd_chk("add1_ax", 0, 11);
`ifdef ALU_FLAGS_EN
    chk("add1_c", {31'd0, flag_c}, 0);
`endif
    tick();
    chk("add2_done", {31'd0, done}, 1);
    rd_chk("add2_ax", 0, 1);
`ifdef ALU_FLAGS_EN
    chk("add2_c", {31'd0, flag_c}, 1);
`endif

    // SUB BX,AX equal operands, then illegal opcode
    ext_load(0, 3);
    ext_load(1, 3);
    issue(3, 1, 0);
    tick();
    issue(4'b1100, 0, 1);
    tick();
    in_valid = 1'b0;
    rd_chk("sub_bx", 1, 0);
    chk("sub_err", {31'd0, err}, 0);
`ifdef ALU_FLAGS_EN
    chk("sub_z", {31'd0, flag_z}, 1);
    chk("sub_c", {31'd0, flag_c}, 0);
`endif
    tick();
    chk("ill_done", {31'd0, done}, 1);
    chk("ill_err", {31'd0, err}, 1);
    rd_chk("ill_ax", 0, 3);
    rd_chk("ill_bx", 1, 0);
`ifdef ALU_FLAGS_EN
    chk("ill_z_kept", {31'd0, flag_z}, 1);
`endif

    // ext_we blocks acceptance for two cycles
    ext_we = 1'b1; ext_addr = 2; ext_data = 9;
    issue(5, 2, 2);
    #1;
    chk("stall_ready", {31'd0, in_ready}, 0);
    tick();
    chk("stall_done1", {31'd0, done}, 0);
    tick();
    chk("stall_done2", {31'd0, done}, 0);
    rd_chk("stall_cx", 2, 9);
    ext_we = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("release_done", {31'd0, done}, 0);
    tick();
    chk("release_retire", {31'd0, done}, 1);
    rd_chk("xor_cx_clear", 2, 0);

    // reset while an instruction sits in execute
    issue(1, 3, 0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_done", {31'd0, done}, 0);
    rd_chk("rst_mid_dx", 3, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after_done", {31'd0, done}, 0);
    rd_chk("rst_after_dx", 3, 0);

    // randomized traffic against the model, starting from the reset state
    for (int i = 0; i < NREGS; i++) m_rf[i] = 0;
    m_z = 0; m_c = 0; m_err = 0;
    pend_v = 0; pend_op = 0; pend_d = 0; pend_s = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 4'($urandom_range(0, 15));
      in_dst   = 2'($urandom_range(0, 3));
      in_src   = 2'($urandom_range(0, 3));
      ext_we   = ($urandom_range(0, 5) == 0);
      ext_addr = 2'($urandom_range(0, 3));
      ext_data = 4'($urandom_range(0, M - 1));
      #1;
      chk("rnd_ready", {31'd0, in_ready}, {31'd0, ~ext_we});
      exp_done = pend_v; exp_err = 0;
      if (pend_v != 0) begin
        model_retire(pend_op, pend_d, pend_s);
        exp_err = m_err;
      end
      if (ext_we) m_rf[ext_addr] = ext_data;
      pend_v = in_valid & ~ext_we;
      pend_op = in_op; pend_d = in_dst; pend_s = in_src;
      tick();
      chk("rnd_done", {31'd0, done}, exp_done);
      chk("rnd_err", {31'd0, err}, exp_err);
      ra = $urandom_range(0, 3);
      rd_chk("rnd_rf", ra, m_rf[ra]);
`ifdef ALU_FLAGS_EN
      chk("rnd_z", {31'd0, flag_z}, m_z);
      chk("rnd_c", {31'd0, flag_c}, m_c);
`endif
    end
    in_valid = 1'b0; ext_we = 1'b0;
    tick();
    for (int i = 0; i < NREGS; i++) rd_chk("final_rf", i, m_rf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
